// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default
// latencies. The decoder and hazard unit use the same encodings.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic mdu_is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: 64-bit product or quotient/remainder
// computed from the operands latched at accept time.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_sx   = signed'({{32{a[31]}}, a});
    assign b_sx   = signed'({{32{b[31]}}, b});
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Select the result for the latched op; a zero divisor yields no write.
    always_comb begin
        res_hi    = '0;
        res_lo    = '0;
        res_valid = 1'b0;
        case (op)
            MDU_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_valid        = 1'b1;
            end
            MDU_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_valid        = 1'b1;
            end
            MDU_DIV: begin
                if (b != '0) begin
                    res_lo    = $signed(a) / $signed(b);
                    res_hi    = $signed(a) % $signed(b);
                    res_valid = 1'b1;
                end
            end
            MDU_DIVU: begin
                if (b != '0) begin
                    res_lo    = a / b;
                    res_hi    = a % b;
                    res_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage. Holds HI/LO, models mult/div latency
// with a down-counter whose nonzero state is Busy, and serves mfhi/mflo/mthi/mtlo.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] Out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    mdu_op_e          op_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_valid;

    assign Busy   = (cnt != '0);
    assign accept = Start && !Busy;

    mdu_arith u_arith (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .res_valid (res_valid)
    );

    // Accept new ops when idle, otherwise count down and write back on the last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= MDU_NONE;
            cnt  <= '0;
        end else if (accept) begin
            if (mdu_is_long_op(MDUOp)) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= mdu_op_e'(MDUOp);
            end
            case (MDUOp)
                MDU_MULT, MDU_MULTU: cnt <= CNT_W'(MULT_CYCLES);
                MDU_DIV,  MDU_DIVU:  cnt <= CNT_W'(DIV_CYCLES);
                MDU_MTHI:            hi  <= A;
                MDU_MTLO:            lo  <= A;
                default: ;
            endcase
        end else if (Busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && res_valid) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // mfhi/mflo read port; zero for every other op code.
    always_comb begin
        Out = '0;
        case (MDUOp)
            MDU_MFHI: Out = hi;
            MDU_MFLO: Out = lo;
            default:  Out = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] Out;

    int checks   = 0;
    int failures = 0;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reads HI and LO through Out, and checks Out is 0 for a non-read op.
    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        MDUOp = 4'd5;
        #1 check32({tag, "_hi"}, Out, exp_hi);
        MDUOp = 4'd6;
        #1 check32({tag, "_lo"}, Out, exp_lo);
        MDUOp = 4'd0;
        #1 check32({tag, "_none"}, Out, 32'd0);
    endtask

    // Presents one op for a single accept edge; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
    endtask

    // Counts negedges with Busy high; bounded.
    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check32({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        check32({tag, "_busy_low"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 4'd0;
        A     = '0;
        B     = '0;
        #1;
        check32("reset_busy", {31'd0, Busy}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Signed / unsigned multiply
        issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done("mult", 5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done("multu", 5);
        read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        // Signed / unsigned divide
        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("div", 10);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(4'd4, 32'd7, 32'd2);
        wait_done("divu", 10);
        read_hilo("divu", 32'd1, 32'd3);

        // Divide by zero leaves HI/LO untouched
        issue(4'd7, 32'h11, 32'd0);
        check32("mthi_busy", {31'd0, Busy}, 32'd0);
        issue(4'd8, 32'h22, 32'd0);
        check32("mtlo_busy", {31'd0, Busy}, 32'd0);
        read_hilo("mtx", 32'h11, 32'h22);
        issue(4'd4, 32'd7, 32'd0);
        wait_done("div0", 10);
        read_hilo("div0", 32'h11, 32'h22);

        // Start held with mtlo while busy must be ignored
        @(negedge clk);
        Start = 1'b1;
        MDUOp = 4'd1;
        A     = 32'd3;
        B     = 32'd4;
        @(negedge clk);
        MDUOp = 4'd8;
        A     = 32'h55;
        n = 0;
        while (Busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        Start = 1'b0;
        MDUOp = 4'd0;
        check32("busy_start_cycles", 32'(n), 32'd5);
        read_hilo("busy_start", 32'd0, 32'd12);

        // Asynchronous reset three cycles into a divide
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check32("rst_mid_busy", {31'd0, Busy}, 32'd0);
        read_hilo("rst_mid", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check32("rst_after_busy", {31'd0, Busy}, 32'd0);
        read_hilo("rst_after", 32'd0, 32'd0);

        // Operand changes during Busy have no effect; Out stays 0 for other ops
        issue(4'd1, 32'd6, 32'd7);
        n = 0;
        while (Busy === 1'b1 && n < 60) begin
            A     = $urandom;
            B     = $urandom;
            MDUOp = (n % 2 == 0) ? 4'd3 : 4'd8;
            #1 check32("stab_out_zero", Out, 32'd0);
            n++;
            @(negedge clk);
        end
        MDUOp = 4'd0;
        check32("stab_cycles", 32'(n), 32'd5);
        read_hilo("stab", 32'd0, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline.
- Consumes `Start` and `MDUOp` from the decoder, and rs/rt operand values from the E-stage forwarding muxes.
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency through `Busy`, which the hazard unit uses to stall.
- Also serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, Busy duration in cycles for div/divu.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  E-stage instruction is an MDU op (MDUOp != 0).
- MDUOp  input  4  1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 0 none.
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- Busy  output  1  multi-cycle operation in progress.
- Out  output  32  HI when MDUOp==5, LO when MDUOp==6, otherwise 0. Combinational.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous, active-high.
- Reset effects:
  - HI=0, LO=0, counter=0, Busy=0.
  - Any operation in flight is abandoned with no HI/LO update.
  - Reset overrides Start in the same cycle.
- Accept rule: an op is accepted at a posedge where `Start`=1 and `Busy`=0.
  - Start while Busy=1 is ignored. The hazard unit must stall on (Start|Busy); the block does not rely on that.
- mult/multu/div/divu, on accept:
  - Latch A and B into internal operand registers.
  - Latch the op code.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Busy goes to 1 in the following cycle.
- Countdown:
  - Counter decrements each posedge while nonzero.
  - At the posedge where the counter goes 1→0, write HI/LO from the latched operands and drop Busy.
  - Busy is therefore high for exactly N cycles after the accept edge. With MULT_CYCLES=5, Busy is high for 5 cycles.
- Arithmetic:
  - mult: {HI,LO} = $signed(A) * $signed(B), 64-bit.
  - multu: unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B==0): the Busy sequence still runs in full; HI and LO stay unchanged.
- mthi/mtlo:
  - Accepted only when Busy=0.
  - HI←A or LO←A at the accept edge.
  - No Busy.
- mfhi/mflo:
  - Out reflects current HI or LO with no latency.
  - No state change, no Busy.
  - While Busy=1, Out shows the old value; the pipeline stalls these instructions.
- Operands are not re-sampled during Busy. Changes on A and B after accept have no effect.
- Out is 0 for all MDUOp values other than 5 and 6.

Decomposition:
- Package `mdu_pkg`:
  - MDUOp encodings (MDU_NONE..MDU_MTLO, 4-bit).
  - Default cycle counts.
  - Decoder and hazard unit share these encodings.
- One natural sub-module, `mdu_arith`: purely combinational 64-bit product and quotient/remainder from the latched operands and op. The top holds the counter, HI/LO and Busy.

Test Plan:
- Signed and unsigned multiply, A=0xFFFFFFFF, B=0x00000002:
  - mult → after 5 Busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu → HI=0x00000001, LO=0xFFFFFFFE.
  - Busy is low the cycle after completion.
- Signed and unsigned divide, A=0xFFFFFFF9 (-7), B=2:
  - div → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
- Divide by zero: mthi 0x11, mtlo 0x22, then divu A=7, B=0 → Busy high for 10 cycles; afterwards HI=0x11, LO=0x22.
- Start during Busy:
  - Issue mult 3*4, then hold Start with mtlo A=0x55 during Busy → mtlo ignored.
  - Final HI=0, LO=12.
  - mfhi (MDUOp=5) gives Out=0.
  - mflo (MDUOp=6) gives Out=12 the cycle after Busy falls.
- Reset mid-operation: reset asserted asynchronously 3 cycles into div 100/7 → immediately Busy=0, HI=LO=0; no later writeback.
- Operand stability: change A and B every cycle during mult 6*7 → LO=42, HI=0. Out=0 whenever MDUOp is not 5 or 6.
